// File: rtl/uart_rx_frame_ctrl_if.sv
// Bus bundle between the UART receive frame controller and its neighbours.
// The line, the edge counter, the sampler and the configuration feed into the
// controller. The enables, the received word and the status pulses come back out.
interface uart_rx_frame_ctrl_if #(
  parameter int PWIDTH = 6,
  parameter int DWIDTH = 8
);
  logic              rx_in;
  logic [PWIDTH-1:0] prescale;
  logic [PWIDTH-1:0] edge_counter;
  logic              sampled_bit;
  logic              par_en;
  logic              par_typ;
  logic              edge_cnt_en;
  logic              data_sampling_en;
  logic [DWIDTH-1:0] p_data;
  logic              data_valid;
  logic              par_err;
  logic              stp_err;
  logic              strt_glitch;
  logic              busy;

  // The upstream side drives the line, the counter, the sampler and the config.
  modport master (
    output rx_in, prescale, edge_counter, sampled_bit, par_en, par_typ,
    input  edge_cnt_en, data_sampling_en, p_data, data_valid,
           par_err, stp_err, strt_glitch, busy
  );

  // The frame controller consumes the line and reports results.
  modport slave (
    input  rx_in, prescale, edge_counter, sampled_bit, par_en, par_typ,
    output edge_cnt_en, data_sampling_en, p_data, data_valid,
           par_err, stp_err, strt_glitch, busy
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller and deserializer.
// The controller detects and validates a start bit. It shifts in DWIDTH data
// bits LSB-first, then checks the optional parity bit and the stop bit.
// A good frame produces one word. A bad frame produces error pulses instead.
module uart_rx_frame_ctrl #(
  parameter int PWIDTH = 6,
  parameter int DWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_rx_frame_ctrl_if.slave  bus
);

  localparam int IWIDTH = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]        r_state;
  logic [PWIDTH-1:0] r_prescale;
  logic              r_par_en;
  logic              r_par_typ;
  logic [DWIDTH-1:0] r_shreg;
  logic [IWIDTH-1:0] r_bit_idx;
  logic              r_par_mis;
  logic [DWIDTH-1:0] r_p_data;
  logic              r_data_valid;
  logic              r_par_err;
  logic              r_stp_err;
  logic              r_strt_glitch;

  logic w_busy;
  logic w_tick;
  logic w_par_exp;
  logic w_last_bit;

  assign w_busy     = (r_state != IDLE);
  assign w_tick     = w_busy && (bus.edge_counter == (r_prescale - PWIDTH'(1)));
  assign w_par_exp  = (^r_shreg) ^ r_par_typ;
  assign w_last_bit = (r_bit_idx == IWIDTH'(DWIDTH - 1));

  assign bus.edge_cnt_en      = w_busy;
  assign bus.data_sampling_en = w_busy;
  assign bus.busy             = w_busy;
  assign bus.p_data           = r_p_data;
  assign bus.data_valid       = r_data_valid;
  assign bus.par_err          = r_par_err;
  assign bus.stp_err          = r_stp_err;
  assign bus.strt_glitch      = r_strt_glitch;

  // Frame sequencing. Bit decisions are made only on the last oversample tick of each bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_prescale    <= '0;
      r_par_en      <= 1'b0;
      r_par_typ     <= 1'b0;
      r_shreg       <= '0;
      r_bit_idx     <= '0;
      r_par_mis     <= 1'b0;
      r_p_data      <= '0;
      r_data_valid  <= 1'b0;
      r_par_err     <= 1'b0;
      r_stp_err     <= 1'b0;
      r_strt_glitch <= 1'b0;
    end else begin
      r_data_valid  <= 1'b0;
      r_par_err     <= 1'b0;
      r_stp_err     <= 1'b0;
      r_strt_glitch <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!bus.rx_in) begin
            r_prescale <= bus.prescale;
            r_par_en   <= bus.par_en;
            r_par_typ  <= bus.par_typ;
            r_par_mis  <= 1'b0;
            r_state    <= START;
          end
        end
        START: begin
          if (w_tick) begin
            if (bus.sampled_bit) begin
              r_strt_glitch <= 1'b1;
              r_state       <= IDLE;
            end else begin
              r_bit_idx <= '0;
              r_state   <= DATA;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shreg   <= {bus.sampled_bit, r_shreg[DWIDTH-1:1]};
            r_bit_idx <= r_bit_idx + IWIDTH'(1);
            if (w_last_bit) begin
              r_state <= r_par_en ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_par_mis <= (bus.sampled_bit != w_par_exp);
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state      <= IDLE;
            r_data_valid <= !r_par_mis && bus.sampled_bit;
            r_par_err    <= r_par_mis;
            r_stp_err    <= !bus.sampled_bit;
            if (!r_par_mis && bus.sampled_bit) begin
              r_p_data <= r_shreg;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
